// File: rtl/mem_watch_pkg.sv
// Shared definitions for the memory watch monitor: FSM state encoding
// and the default counter width.
package mem_watch_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_STOPPED  = 2'd2
    } watch_state_e;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/mem_watch_chan.sv
// One monitored bus channel: saturating read/write access counters and the
// watchpoint compare for this channel.
// Optional feature: WATCH_DATA_EN adds a per-byte write-data compare.
module mem_watch_chan
    import mem_watch_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                armed,
    input  logic [ADDR_W-1:0]   cfg_wp_addr,
    input  logic [ADDR_W-1:0]   cfg_wp_mask,
    input  logic                cfg_wp_wr,
`ifdef WATCH_DATA_EN
    input  logic [DATA_W-1:0]   cfg_wp_data,
    input  logic [DATA_W/8-1:0] cfg_wp_bmask,
`endif
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic                match
);

    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             is_wr;
    logic             addr_ok;
    logic             data_ok;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign is_wr   = |wstrb;
    assign addr_ok = ((addr ^ cfg_wp_addr) & cfg_wp_mask) == '0;

`ifdef WATCH_DATA_EN
    // Data qualifier: every byte both written and selected must equal the watch data.
    always_comb begin
        data_ok = 1'b1;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b] && cfg_wp_bmask[b] && (wdata[b*8 +: 8] != cfg_wp_data[b*8 +: 8]))
                data_ok = 1'b0;
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata;
    assign data_ok      = 1'b1;
`endif

    assign match = armed && valid && (is_wr == cfg_wp_wr) && addr_ok && data_ok;

    // Next counter values; clr wins over a same-cycle access.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (clr) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else if (valid) begin
            if (is_wr) wr_cnt_d = sat_inc(wr_cnt_q);
            else       rd_cnt_d = sat_inc(rd_cnt_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: rtl/mem_watch_monitor.sv
// Memory bus watch monitor: per-channel access counters plus one address
// watchpoint with hit reporting and an optional hit-count stop.
// Optional feature: WATCH_DATA_EN adds cfg_wp_data/cfg_wp_bmask data matching.
module mem_watch_monitor
    import mem_watch_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = CNT_W_DEFAULT,
    localparam int HCH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            mon_valid,
    input  logic [N_CH*ADDR_W-1:0]     mon_addr,
    input  logic [N_CH*DATA_W/8-1:0]   mon_wstrb,
    input  logic [N_CH*DATA_W-1:0]     mon_wdata,
    input  logic                       cfg_en,
    input  logic [ADDR_W-1:0]          cfg_wp_addr,
    input  logic [ADDR_W-1:0]          cfg_wp_mask,
    input  logic                       cfg_wp_wr,
    input  logic [CNT_W-1:0]           cfg_hit_limit,
`ifdef WATCH_DATA_EN
    input  logic [DATA_W-1:0]          cfg_wp_data,
    input  logic [DATA_W/8-1:0]        cfg_wp_bmask,
`endif
    input  logic                       clr,
    output logic [N_CH*CNT_W-1:0]      rd_cnt,
    output logic [N_CH*CNT_W-1:0]      wr_cnt,
    output logic                       hit,
    output logic [HCH_W-1:0]           hit_ch,
    output logic [ADDR_W-1:0]          hit_addr,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       stop
);

    localparam int SB = DATA_W/8;

    watch_state_e      state_q, state_d;
    logic              hit_q, hit_d;
    logic [HCH_W-1:0]  hit_ch_q, hit_ch_d;
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [N_CH-1:0]   match;
    logic              armed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign armed = (state_q == ST_ARMED);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        mem_watch_chan #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .clr         (clr),
            .valid       (mon_valid[k]),
            .addr        (mon_addr[k*ADDR_W +: ADDR_W]),
            .wstrb       (mon_wstrb[k*SB +: SB]),
            .wdata       (mon_wdata[k*DATA_W +: DATA_W]),
            .armed       (armed),
            .cfg_wp_addr (cfg_wp_addr),
            .cfg_wp_mask (cfg_wp_mask),
            .cfg_wp_wr   (cfg_wp_wr),
`ifdef WATCH_DATA_EN
            .cfg_wp_data (cfg_wp_data),
            .cfg_wp_bmask(cfg_wp_bmask),
`endif
            .rd_cnt      (rd_cnt[k*CNT_W +: CNT_W]),
            .wr_cnt      (wr_cnt[k*CNT_W +: CNT_W]),
            .match       (match[k])
        );
    end

    // Hit capture (lowest matching channel wins) and watch FSM next state.
    always_comb begin
        state_d    = state_q;
        hit_d      = 1'b0;
        hit_ch_d   = hit_ch_q;
        hit_addr_d = hit_addr_q;
        hit_cnt_d  = hit_cnt_q;

        for (int k = N_CH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit_ch_d   = HCH_W'(k);
                hit_addr_d = mon_addr[k*ADDR_W +: ADDR_W];
            end
        end
        if (|match) begin
            hit_d     = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
        end

        case (state_q)
            ST_DISARMED: if (cfg_en) state_d = ST_ARMED;
            ST_ARMED: begin
                if ((|match) && (cfg_hit_limit != '0) && (hit_cnt_d == cfg_hit_limit))
                    state_d = ST_STOPPED;
                else if (!cfg_en)
                    state_d = ST_DISARMED;
            end
            ST_STOPPED:  state_d = ST_STOPPED;
            default:     state_d = ST_DISARMED;
        endcase

        if (clr) begin
            state_d    = ST_DISARMED;
            hit_d      = 1'b0;
            hit_ch_d   = '0;
            hit_addr_d = '0;
            hit_cnt_d  = '0;
        end
    end

    // FSM and hit report registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DISARMED;
            hit_q      <= 1'b0;
            hit_ch_q   <= '0;
            hit_addr_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            hit_ch_q   <= hit_ch_d;
            hit_addr_q <= hit_addr_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign hit      = hit_q;
    assign hit_ch   = hit_ch_q;
    assign hit_addr = hit_addr_q;
    assign hit_cnt  = hit_cnt_q;
    assign stop     = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_mem_watch_monitor.sv
// Self-checking bench for mem_watch_monitor: directed scenarios plus a
// randomized run, all compared against a behavioural model.
module tb_mem_watch_monitor;

    localparam int N_CH   = 2;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int SB     = DATA_W/8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [N_CH-1:0]          mon_valid = '0;
    logic [N_CH*ADDR_W-1:0]   mon_addr = '0;
    logic [N_CH*SB-1:0]       mon_wstrb = '0;
    logic [N_CH*DATA_W-1:0]   mon_wdata = '0;
    logic                     cfg_en = 1'b0;
    logic [ADDR_W-1:0]        cfg_wp_addr = '0;
    logic [ADDR_W-1:0]        cfg_wp_mask = '0;
    logic                     cfg_wp_wr = 1'b0;
    logic [CNT_W-1:0]         cfg_hit_limit = '0;
`ifdef WATCH_DATA_EN
    logic [DATA_W-1:0]        cfg_wp_data = '0;
    logic [SB-1:0]            cfg_wp_bmask = '0;
`endif
    logic                     clr = 1'b0;
    logic [N_CH*CNT_W-1:0]    rd_cnt, wr_cnt;
    logic                     hit;
    logic [0:0]               hit_ch;
    logic [ADDR_W-1:0]        hit_addr;
    logic [CNT_W-1:0]         hit_cnt;
    logic                     stop;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: mode 0 = disarmed, 1 = armed, 2 = stopped
    int m_rd[N_CH], m_wr[N_CH];
    int m_hit, m_hit_ch, m_hit_addr, m_hit_cnt, m_mode;

    mem_watch_monitor #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .mon_valid(mon_valid), .mon_addr(mon_addr), .mon_wstrb(mon_wstrb), .mon_wdata(mon_wdata),
        .cfg_en(cfg_en), .cfg_wp_addr(cfg_wp_addr), .cfg_wp_mask(cfg_wp_mask),
        .cfg_wp_wr(cfg_wp_wr), .cfg_hit_limit(cfg_hit_limit),
`ifdef WATCH_DATA_EN
        .cfg_wp_data(cfg_wp_data), .cfg_wp_bmask(cfg_wp_bmask),
`endif
        .clr(clr),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .hit(hit), .hit_ch(hit_ch),
        .hit_addr(hit_addr), .hit_cnt(hit_cnt), .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit ch_match(input int k);
        logic [ADDR_W-1:0] a;
        logic [SB-1:0]     s;
        bit                is_wr;
`ifdef WATCH_DATA_EN
        logic [DATA_W-1:0] d;
        d = mon_wdata[k*DATA_W +: DATA_W];
`endif
        if (!mon_valid[k]) return 0;
        a = mon_addr[k*ADDR_W +: ADDR_W];
        s = mon_wstrb[k*SB +: SB];
        is_wr = (s != 0);
        if (is_wr != cfg_wp_wr) return 0;
        for (int i = 0; i < ADDR_W; i++)
            if (cfg_wp_mask[i] && (a[i] != cfg_wp_addr[i])) return 0;
`ifdef WATCH_DATA_EN
        if (is_wr)
            for (int b = 0; b < SB; b++)
                if (s[b] && cfg_wp_bmask[b] && (d[b*8 +: 8] != cfg_wp_data[b*8 +: 8])) return 0;
`endif
        return 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N_CH; k++) begin m_rd[k] = 0; m_wr[k] = 0; end
        m_hit = 0; m_hit_ch = 0; m_hit_addr = 0; m_hit_cnt = 0; m_mode = 0;
    endtask

    // Advance model and DUT by one clock, then compare every output.
    task automatic step();
        bit any;
        int lo;
        if (reset || clr) begin
            model_clear();
        end else begin
            any = 0; lo = 0;
            if (m_mode == 1)
                for (int k = 0; k < N_CH; k++)
                    if (!any && ch_match(k)) begin any = 1; lo = k; end
            for (int k = 0; k < N_CH; k++)
                if (mon_valid[k]) begin
                    if (mon_wstrb[k*SB +: SB] != 0) m_wr[k] = sat(m_wr[k]);
                    else                            m_rd[k] = sat(m_rd[k]);
                end
            m_hit = any;
            if (any) begin
                m_hit_ch   = lo;
                m_hit_addr = int'(mon_addr[lo*ADDR_W +: ADDR_W]);
                m_hit_cnt  = sat(m_hit_cnt);
            end
            if (m_mode == 0) begin
                if (cfg_en) m_mode = 1;
            end else if (m_mode == 1) begin
                if (any && cfg_hit_limit != 0 && m_hit_cnt == int'(cfg_hit_limit)) m_mode = 2;
                else if (!cfg_en) m_mode = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N_CH; k++) begin
            chk($sformatf("rd_cnt%0d", k), 64'(rd_cnt[k*CNT_W +: CNT_W]), 64'(m_rd[k]));
            chk($sformatf("wr_cnt%0d", k), 64'(wr_cnt[k*CNT_W +: CNT_W]), 64'(m_wr[k]));
        end
        chk("hit",      64'(hit),      64'(m_hit));
        chk("hit_ch",   64'(hit_ch),   64'(m_hit_ch));
        chk("hit_addr", 64'(hit_addr), 64'(m_hit_addr));
        chk("hit_cnt",  64'(hit_cnt),  64'(m_hit_cnt));
        chk("stop",     64'(stop),     64'(m_mode == 2));
    endtask

    task automatic idle_bus();
        mon_valid = '0; mon_wstrb = '0; mon_addr = '0; mon_wdata = '0;
    endtask

    task automatic drive(input int k, input logic [ADDR_W-1:0] a, input logic [SB-1:0] s,
                         input logic [DATA_W-1:0] d);
        mon_valid[k] = 1'b1;
        mon_addr[k*ADDR_W +: ADDR_W] = a;
        mon_wstrb[k*SB +: SB] = s;
        mon_wdata[k*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        model_clear();

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("reset_stop",    64'(stop),    64'd0);

        // Five-cycle read burst on ch0
        drive(0, 18'h00010, '0, '0);
        repeat (5) step();
        idle_bus();
        chk("burst_rd0", 64'(rd_cnt[CNT_W-1:0]), 64'd5);
        chk("burst_wr0", 64'(wr_cnt[CNT_W-1:0]), 64'd0);

        // Single write hit on ch1
        cfg_wp_addr = 18'h3ffda; cfg_wp_mask = '1; cfg_wp_wr = 1'b1; cfg_hit_limit = '0;
        cfg_en = 1'b1;
        step();
        drive(1, 18'h3ffda, 4'hf, 32'h1);
        step();
        idle_bus();
        chk("wr_hit_pulse", 64'(hit),      64'd1);
        chk("wr_hit_ch",    64'(hit_ch),   64'd1);
        chk("wr_hit_addr",  64'(hit_addr), 64'h3ffda);
        chk("wr_hit_cnt",   64'(hit_cnt),  64'd1);
        step();
        chk("hit_one_cycle", 64'(hit), 64'd0);
        chk("hit_addr_held", 64'(hit_addr), 64'h3ffda);

        // Simultaneous matches on both channels
        drive(0, 18'h3ffda, 4'h1, 32'h2);
        drive(1, 18'h3ffda, 4'h2, 32'h3);
        step();
        idle_bus();
        chk("dual_hit_ch",  64'(hit_ch),  64'd0);
        chk("dual_hit_cnt", 64'(hit_cnt), 64'd2);

        // Hit limit of 3 with four matching writes
        clr = 1'b1; step(); clr = 1'b0;
        cfg_hit_limit = 4'd3;
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 18'h3ffda, 4'hf, 32'(i));
            step();
            if (i == 2) chk("limit_stop_at3", 64'(stop), 64'd1);
        end
        idle_bus();
        chk("limit_hit_cnt", 64'(hit_cnt), 64'd3);
        chk("limit_wr0",     64'(wr_cnt[CNT_W-1:0]), 64'd4);
        chk("limit_stop",    64'(stop), 64'd1);

        // Counter saturation, then clr racing a read
        clr = 1'b1; step(); clr = 1'b0;
        cfg_en = 1'b0; cfg_hit_limit = '0;
        drive(0, 18'h00005, '0, '0);
        repeat (20) step();
        chk("sat_rd0", 64'(rd_cnt[CNT_W-1:0]), 64'd15);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle_bus();
        chk("clr_rd0", 64'(rd_cnt[CNT_W-1:0]), 64'd0);

`ifdef WATCH_DATA_EN
        // Byte-qualified data watch
        cfg_wp_addr = 18'h00100; cfg_wp_mask = '1; cfg_wp_wr = 1'b1;
        cfg_wp_data = 32'h000000ab; cfg_wp_bmask = 4'b0001;
        cfg_en = 1'b1;
        step();
        drive(0, 18'h00100, 4'hf, 32'h000012ab);
        step();
        drive(0, 18'h00100, 4'hf, 32'h000012ac);
        step();
        idle_bus();
        step();
        chk("data_hit_cnt", 64'(hit_cnt), 64'd1);
`endif

        // Randomized traffic
        cfg_wp_mask = 18'h3fff0; cfg_wp_addr = 18'h2a5c0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 150 == 0) begin
                cfg_wp_addr   = ADDR_W'($urandom);
                cfg_wp_mask   = ADDR_W'($urandom) | 18'h3f000;
                cfg_wp_wr     = 1'($urandom);
                cfg_hit_limit = CNT_W'($urandom_range(0, 6));
`ifdef WATCH_DATA_EN
                cfg_wp_data  = $urandom;
                cfg_wp_bmask = SB'($urandom);
`endif
            end
            reset  = ($urandom_range(0, 299) == 0);
            clr    = ($urandom_range(0, 59) == 0);
            cfg_en = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < N_CH; k++) begin
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] d;
                a = ($urandom_range(0, 2) != 0) ? (cfg_wp_addr ^ (ADDR_W'($urandom) & ~cfg_wp_mask))
                                                : ADDR_W'($urandom);
                d = $urandom;
`ifdef WATCH_DATA_EN
                if ($urandom_range(0, 1) == 1) d = cfg_wp_data ^ (d & 32'hff00ff00);
`endif
                mon_valid[k] = 1'($urandom);
                mon_addr[k*ADDR_W +: ADDR_W] = a;
                mon_wstrb[k*SB +: SB] = ($urandom_range(0, 1) == 0) ? '0 : SB'($urandom);
                mon_wdata[k*DATA_W +: DATA_W] = d;
            end
            step();
        end
        reset = 1'b0; clr = 1'b0;
        idle_bus();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_watch_monitor.md
MEM_WATCH_MONITOR -- requirements
Module: mem_watch_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of monitored memory bus channels (instruction and data).
REQ-002 SHALL have parameter ADDR_W, default 13, monitored address width in words.
REQ-003 SHALL have parameter DATA_W, default 32, monitored data width, a multiple of 8.
REQ-004 SHALL have parameter CNT_W, default 32, width of access and hit counters.
REQ-005 SHALL have port clk input 1 system clock; one clock domain; all state updates on its rising edge.
REQ-006 SHALL have port reset input 1 reset; synchronous, active-high.
REQ-007 SHALL have port mon_valid input N_CH per-channel access valid.
REQ-008 SHALL have port mon_addr input N_CH*ADDR_W per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port mon_wstrb input N_CH*DATA_W/8 per-channel write strobe; an all-zero strobe marks a read.
REQ-010 SHALL have port mon_wdata input N_CH*DATA_W per-channel write data.
REQ-011 SHALL have port cfg_en input 1 watchpoint arm request.
REQ-012 SHALL have port cfg_wp_addr input ADDR_W watch address.
REQ-013 SHALL have port cfg_wp_mask input ADDR_W watch address compare mask; 1 = bit compared.
REQ-014 SHALL have port cfg_wp_wr input 1 watch access type; 1 = writes, 0 = reads.
REQ-015 SHALL have port cfg_hit_limit input CNT_W hit count that stops the monitor; 0 = never stop.
REQ-016 SHALL have port clr input 1 clears all counters and state.
REQ-017 SHALL have port rd_cnt output N_CH*CNT_W per-channel read count.
REQ-018 SHALL have port wr_cnt output N_CH*CNT_W per-channel write count.
REQ-019 SHALL have port hit output 1 one-cycle watch hit pulse.
REQ-020 SHALL have port hit_ch output $clog2(N_CH) (minimum 1) channel index of the hit.
REQ-021 SHALL have port hit_addr output ADDR_W address of the hit.
REQ-022 SHALL have port hit_cnt output CNT_W total hit count.
REQ-023 SHALL have port stop output 1 sticky stop flag.

Function
REQ-024 SHALL count, per channel and per cycle, mon_valid&|wstrb as a write and mon_valid&~|wstrb as a read; mon_valid held N cycles counts N.
REQ-025 SHALL saturate every counter at all-ones, with no wrap.
REQ-026 SHALL implement states DISARMED, ARMED and STOPPED: DISARMED->ARMED when cfg_en=1; ARMED->DISARMED when cfg_en=0; ARMED->STOPPED when a hit makes hit_cnt equal cfg_hit_limit (nonzero); STOPPED->DISARMED only on clr.
REQ-027 SHALL define a channel match, only in ARMED, as a valid access of the cfg_wp_wr type with ((addr^cfg_wp_addr)&cfg_wp_mask)==0.
REQ-028 SHALL register hit, hit_ch, hit_addr and hit_cnt, updated the cycle after the match (latency 1); stop asserts in that same cycle.
REQ-029 SHALL, on same-cycle matches on several channels, report the lowest channel index and increment hit_cnt by exactly 1.
REQ-030 SHALL hold hit_ch and hit_addr until the next hit.
REQ-031 SHALL keep the access counters running in STOPPED; hits are not counted in STOPPED.
REQ-032 SHALL give clr priority over a simultaneous access or hit: the counters read 0 the next cycle.

Reset
REQ-033 SHALL, on reset, enter DISARMED and drive every output, counter and hit register to 0; reset mid-hit drops the pending pulse.

Configuration
REQ-034 SHALL, with WATCH_DATA_EN defined, add inputs cfg_wp_data (DATA_W) and cfg_wp_bmask (DATA_W/8); a write match then also requires equal data on every byte where both the strobe and cfg_wp_bmask are set.
REQ-035 SHALL, without WATCH_DATA_EN, omit those ports and match on address and access type only.

Structure
REQ-036 SHALL place the state encoding and the default counter-width constant in package mem_watch_pkg.
REQ-037 SHALL use sub-module mem_watch_chan (read/write counters plus match compare for one channel), generated N_CH times.

Verification
REQ-038 SHALL cover: ch0 valid, wstrb=0, 5 cycles -> rd_cnt[0]=5, wr_cnt[0]=0.
REQ-039 SHALL cover: armed, wp_addr=0x3ffda, mask=all-ones, wr=1, ch1 write 0x3ffda -> hit pulse next cycle, hit_ch=1, hit_addr=0x3ffda, hit_cnt=1.
REQ-040 SHALL cover: both channels match the same cycle -> hit_ch=0, hit_cnt increments by 1.
REQ-041 SHALL cover: cfg_hit_limit=3, four matching writes -> stop after the third, hit_cnt stays 3, wr_cnt=4.
REQ-042 SHALL cover: CNT_W=4, 20 reads -> rd_cnt=15; clr together with a read -> rd_cnt=0.
REQ-043 SHALL cover, with WATCH_DATA_EN: bmask=4'b0001, data 0xAB, writes of 0x12AB then 0x12AC -> exactly one hit.
